// File: rtl/bip_run_ctrl_pkg.sv
// bip_ctrl_defs: shared command bytes, HALT opcode and controller state encodings
package bip_ctrl_defs;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [4:0] HALT_OP  = 5'b00000;
  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_HI, LD_LO, LD_WR, LD_RST, RUN, STEP, REPORT, TX
  } st_t;
endpackage

// File: rtl/bip_run_ctrl_if.sv
// bip_run_ctrl_if: UART byte, program-memory write and CPU control signals of the run controller
// master = controller side, slave = UART/memory/CPU side
interface bip_run_ctrl_if #(parameter int PM_AW = 11);
  logic [7:0] rx_data;
  logic rx_done;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_done;
  logic pm_we;
  logic [PM_AW-1:0] pm_addr;
  logic [15:0] pm_wdata;
  logic [15:0] instruction;
  logic [PM_AW-1:0] pc;
  logic [15:0] acc;
  logic cpu_en;
  logic cpu_reset;
  logic busy;
  modport master(
    input rx_data, rx_done, tx_done, instruction, pc, acc,
    output tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, cpu_reset, busy
  );
  modport slave(
    output rx_data, rx_done, tx_done, instruction, pc, acc,
    input tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, cpu_reset, busy
  );
endinterface

// File: rtl/bip_run_ctrl_report_serializer.sv
// report_serializer: sends a 48-bit snapshot MSB-first as 6 bytes over a tx_start/tx_done handshake
// ports: clk, reset (sync, active-low), load/load_data in; tx_data/tx_start out, tx_done in, done out
module report_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [47:0] load_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        done
);
  logic [39:0] sr;
  logic [2:0] left;
  logic act;
  logic ack;
  // a tx_done coinciding with our own tx_start belongs to an earlier byte
  assign ack = act && tx_done && !tx_start;
  assign done = ack && left == 3'd0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_data <= '0;
      tx_start <= 1'b0;
      sr <= '0;
      left <= '0;
      act <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (load) begin
        tx_data <= load_data[47:40];
        sr <= load_data[39:0];
        tx_start <= 1'b1;
        left <= 3'd5;
        act <= 1'b1;
      end else if (ack) begin
        act <= left != 3'd0;
        if (left != 3'd0) begin
          tx_data <= sr[39:32];
          sr <= {sr[31:0], 8'h00};
          tx_start <= 1'b1;
          left <= left - 3'd1;
        end
      end
    end
  end
endmodule

// File: rtl/bip_run_ctrl.sv
// bip_run_ctrl: host command FSM that loads program memory, runs or steps the CPU and reports PC/ACC/cycles
// ports: clk, reset (sync, active-low), bus (bip_run_ctrl_if.master: UART bytes, pm write port, CPU control)
module bip_run_ctrl #(
  parameter int PM_AW = 11,
  parameter logic [4:0] HALT_OP = 5'b00000
) (
  input logic clk,
  input logic reset,
  bip_run_ctrl_if.master bus
);
  import bip_ctrl_defs::*;
  st_t st;
  logic [7:0] n;
  logic [7:0] idx;
  logic [15:0] cnt;
  logic halt;
  logic abort;
  logic last;
  logic done;
  assign halt = bus.instruction[15:11] == HALT_OP;
  assign abort = bus.rx_done && bus.rx_data == CMD_HALT;
  assign last = idx == n - 8'd1;
  // an abort cycle must not advance the CPU
  assign bus.cpu_en = (st == RUN && !halt && !abort) || (st == STEP && !halt);
  assign bus.busy = st != IDLE;
  report_serializer u_ser (
    .clk(clk),
    .reset(reset),
    .load(st == REPORT),
    .load_data({16'(bus.pc), bus.acc, cnt}),
    .tx_data(bus.tx_data),
    .tx_start(bus.tx_start),
    .tx_done(bus.tx_done),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      n <= '0;
      idx <= '0;
      cnt <= '0;
      bus.pm_we <= 1'b0;
      bus.pm_addr <= '0;
      bus.pm_wdata <= '0;
      bus.cpu_reset <= 1'b0;
    end else begin
      bus.pm_we <= 1'b0;
      bus.cpu_reset <= !(st == LD_WR && last);
      // idle holds the counter clear so every run/step starts from zero
      cnt <= st == IDLE ? 16'd0 : cnt + {15'd0, bus.cpu_en && cnt != 16'hFFFF};
      case (st)
        IDLE: if (bus.rx_done)
          st <= bus.rx_data == CMD_LOAD ? LD_CNT :
                bus.rx_data == CMD_RUN  ? RUN :
                bus.rx_data == CMD_STEP ? STEP : IDLE;
        LD_CNT: if (bus.rx_done) begin
          n <= bus.rx_data;
          idx <= '0;
          st <= bus.rx_data == 8'd0 ? IDLE : LD_HI;
        end
        LD_HI: if (bus.rx_done) begin
          bus.pm_wdata <= {bus.pm_wdata[7:0], bus.rx_data};
          st <= LD_LO;
        end
        LD_LO: if (bus.rx_done) begin
          bus.pm_wdata <= {bus.pm_wdata[7:0], bus.rx_data};
          bus.pm_we <= 1'b1;
          bus.pm_addr <= PM_AW'(idx);
          st <= LD_WR;
        end
        LD_WR: begin
          idx <= idx + 8'd1;
          st <= last ? LD_RST : LD_HI;
        end
        LD_RST: st <= IDLE;
        RUN: if (halt || abort) st <= REPORT;
        STEP: st <= REPORT;
        REPORT: st <= TX;
        TX: if (done) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bip_run_ctrl.sv
// tb_bip_run_ctrl: randomized self-checking bench with a toy CPU, UART responder and ISA-level reference
module tb_bip_run_ctrl;
  import bip_ctrl_defs::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  bip_run_ctrl_if #(.PM_AW(11)) bus();
  bip_run_ctrl #(.PM_AW(11), .HALT_OP(5'b00000)) dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  // toy CPU: op 0 HALT, op 1 JMP imm, op 2 ADD imm, others NOP
  logic [15:0] mem [0:2047];
  logic [10:0] cpc;
  logic [15:0] cacc;
  assign bus.instruction = mem[cpc];
  assign bus.pc = cpc;
  assign bus.acc = cacc;
  always @(posedge clk) begin
    if (bus.pm_we) mem[bus.pm_addr] <= bus.pm_wdata;
    if (!bus.cpu_reset) begin
      cpc <= '0;
      cacc <= '0;
    end else if (bus.cpu_en) begin
      if (mem[cpc][15:11] == 5'd1) cpc <= mem[cpc][10:0];
      else begin
        if (mem[cpc][15:11] == 5'd2) cacc <= cacc + {5'd0, mem[cpc][10:0]};
        cpc <= cpc + 11'd1;
      end
    end
  end
  int en_cnt = 0;
  int we_cnt = 0;
  int rst_lo_cnt = 0;
  always @(posedge clk) if (bus.cpu_en) en_cnt++;
  always @(negedge clk) if (bus.pm_we) we_cnt++;
  always @(negedge clk) if (reset && !bus.cpu_reset) rst_lo_cnt++;
  // UART transmitter model with random latency and occasional tx_done overlapping tx_start
  logic [7:0] txq [$];
  int done_cnt = 0;
  int proto_err = 0;
  initial begin
    bit spur;
    int d;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1 && reset) begin
        txq.push_back(bus.tx_data);
        spur = $urandom_range(0, 3) == 0;
        bus.tx_done = spur;
        d = $urandom_range(spur ? 2 : 1, 4);
        repeat (d) begin
          @(negedge clk);
          bus.tx_done = 1'b0;
          if (bus.tx_start === 1'b1) proto_err++;
        end
        if (reset) begin
          bus.tx_done = 1'b1;
          done_cnt++;
        end
      end else bus.tx_done = 1'b0;
    end
  end
  // ISA-level reference of the program the bench loaded
  logic [15:0] ref_mem [0:2047];
  logic [10:0] r_pc = '0;
  logic [15:0] r_acc = '0;
  task automatic ref_go(input int limit, output logic [15:0] c);
    int k = 0;
    logic [15:0] w;
    while (k < limit && ref_mem[r_pc][15:11] != 5'd0) begin
      w = ref_mem[r_pc];
      if (w[15:11] == 5'd1) r_pc = w[10:0];
      else begin
        if (w[15:11] == 5'd2) r_acc = r_acc + {5'd0, w[10:0]};
        r_pc = r_pc + 11'd1;
      end
      k++;
    end
    c = k > 65535 ? 16'hFFFF : 16'(k);
  endtask
  task automatic strobe(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    strobe(b);
    repeat (2) @(negedge clk);
  endtask
  task automatic load_prog(input logic [15:0] w [$]);
    send(CMD_LOAD);
    send(8'(w.size()));
    foreach (w[i]) begin
      send(w[i][15:8]);
      send(w[i][7:0]);
      ref_mem[i] = w[i];
    end
    repeat (2) @(negedge clk);
    r_pc = '0;
    r_acc = '0;
  endtask
  task automatic wait_idle(output bit ok);
    int k = 0;
    while (bus.busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    ok = !bus.busy;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.tx_start, bus.tx_data, bus.pm_we, bus.pm_addr, bus.pm_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b data=%h we=%b addr=%h wdata=%h want all 0",
               bus.tx_start, bus.tx_data, bus.pm_we, bus.pm_addr, bus.pm_wdata);
    end
    checks++;
    if ({bus.cpu_en, bus.busy, bus.cpu_reset} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got en/busy/cpu_reset=%b want 000", {bus.cpu_en, bus.busy, bus.cpu_reset});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_cpu_reset: got %b want 1", bus.cpu_reset);
    end
    send(8'h41);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_noncmd: busy got %b want 0", bus.busy);
    end
  endtask
  task automatic test_load;
    int we0 = we_cnt;
    int rl0 = rst_lo_cnt;
    logic [15:0] w [2] = '{16'h0801, 16'h1802};
    send(CMD_LOAD);
    send(8'd2);
    for (int i = 0; i < 2; i++) begin
      send(w[i][15:8]);
      @(negedge clk);
      strobe(w[i][7:0]);
      checks++;
      if ({bus.pm_we, bus.pm_addr, bus.pm_wdata} !== {1'b1, 11'(i), w[i]}) begin
        errors++;
        $display("FAIL load_write%0d: got we=%b addr=%h data=%h want 1 %h %h",
                 i, bus.pm_we, bus.pm_addr, bus.pm_wdata, 11'(i), w[i]);
      end
      ref_mem[i] = w[i];
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    r_pc = '0;
    r_acc = '0;
    checks++;
    if (we_cnt - we0 != 2) begin
      errors++;
      $display("FAIL load_we_count: got %0d want 2", we_cnt - we0);
    end
    checks++;
    if (rst_lo_cnt - rl0 != 1) begin
      errors++;
      $display("FAIL load_cpu_reset_cycles: got %0d want 1", rst_lo_cnt - rl0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_busy_end: got %b want 0", bus.busy);
    end
    we0 = we_cnt;
    rl0 = rst_lo_cnt;
    send(CMD_LOAD);
    send(8'd0);
    checks++;
    if (bus.busy !== 1'b0 || we_cnt != we0 || rst_lo_cnt != rl0) begin
      errors++;
      $display("FAIL load_zero: got busy=%b writes=%0d resets=%0d want 0 0 0",
               bus.busy, we_cnt - we0, rst_lo_cnt - rl0);
    end
  endtask
  task automatic test_run;
    for (int it = 0; it < 4; it++) begin
      logic [15:0] p [$];
      int len = it == 0 ? 3 : $urandom_range(1, 8);
      int en0, b0;
      bit ok;
      logic [15:0] c;
      logic [47:0] e;
      for (int i = 0; i < len; i++) p.push_back({5'($urandom_range(2, 31)), 11'($urandom)});
      p.push_back(16'h0000);
      load_prog(p);
      en0 = en_cnt;
      b0 = txq.size();
      send(CMD_RUN);
      wait_idle(ok);
      ref_go(100000, c);
      e = {5'd0, r_pc, r_acc, c};
      checks++;
      if (!ok || en_cnt - en0 != len) begin
        errors++;
        $display("FAIL run%0d_cpu_en: got %0d cycles idle=%b want %0d", it, en_cnt - en0, ok, len);
      end
      checks++;
      if (txq.size() - b0 != 6) begin
        errors++;
        $display("FAIL run%0d_bytes: got %0d want 6", it, txq.size() - b0);
      end else for (int i = 0; i < 6; i++) begin
        checks++;
        if (txq[b0 + i] !== e[47 - 8 * i -: 8]) begin
          errors++;
          $display("FAIL run%0d_byte%0d: got %h want %h", it, i, txq[b0 + i], e[47 - 8 * i -: 8]);
        end
      end
    end
  endtask
  task automatic test_step;
    logic [15:0] p [$];
    for (int i = 0; i < 4; i++) p.push_back({5'($urandom_range(2, 31)), 11'($urandom)});
    p.push_back(16'h0000);
    for (int s = 0; s < 7; s++) begin
      int en0, b0;
      bit ok;
      logic [15:0] c;
      logic [47:0] e;
      if (s == 1) load_prog(p);
      en0 = en_cnt;
      b0 = txq.size();
      @(negedge clk);
      strobe(CMD_STEP);
      @(negedge clk);
      checks++;
      if (bus.tx_start !== 1'b0) begin
        errors++;
        $display("FAIL step%0d_early_tx: got %b want 0", s, bus.tx_start);
      end
      @(negedge clk);
      checks++;
      if (bus.tx_start !== 1'b1) begin
        errors++;
        $display("FAIL step%0d_tx_latency: got %b want 1", s, bus.tx_start);
      end
      wait_idle(ok);
      ref_go(1, c);
      e = {5'd0, r_pc, r_acc, c};
      checks++;
      if (!ok || en_cnt - en0 != int'(c)) begin
        errors++;
        $display("FAIL step%0d_cpu_en: got %0d idle=%b want %0d", s, en_cnt - en0, ok, c);
      end
      checks++;
      if (txq.size() - b0 != 6) begin
        errors++;
        $display("FAIL step%0d_bytes: got %0d want 6", s, txq.size() - b0);
      end else for (int i = 0; i < 6; i++) begin
        checks++;
        if (txq[b0 + i] !== e[47 - 8 * i -: 8]) begin
          errors++;
          $display("FAIL step%0d_byte%0d: got %h want %h", s, i, txq[b0 + i], e[47 - 8 * i -: 8]);
        end
      end
    end
  endtask
  task automatic test_abort(input int k);
    int en0 = en_cnt;
    int b0 = txq.size();
    bit ok;
    logic [15:0] c;
    logic [47:0] e;
    @(negedge clk);
    strobe(CMD_RUN);
    for (int j = 1; j <= k; j++) begin
      bus.rx_data = CMD_STEP;
      bus.rx_done = j == k / 2 && j >= 2;
      @(negedge clk);
    end
    bus.rx_done = 1'b0;
    #1;
    checks++;
    if (bus.cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL abort%0d_running: cpu_en got %b want 1", k, bus.cpu_en);
    end
    bus.rx_data = CMD_HALT;
    bus.rx_done = 1'b1;
    #1;
    checks++;
    if (bus.cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL abort%0d_cycle_en: cpu_en got %b want 0", k, bus.cpu_en);
    end
    @(negedge clk);
    bus.rx_done = 1'b0;
    wait_idle(ok);
    ref_go(k, c);
    e = {5'd0, r_pc, r_acc, c};
    checks++;
    if (!ok || en_cnt - en0 != k) begin
      errors++;
      $display("FAIL abort%0d_cpu_en: got %0d idle=%b want %0d", k, en_cnt - en0, ok, k);
    end
    checks++;
    if (txq.size() - b0 != 6) begin
      errors++;
      $display("FAIL abort%0d_bytes: got %0d want 6", k, txq.size() - b0);
    end else for (int i = 0; i < 6; i++) begin
      checks++;
      if (txq[b0 + i] !== e[47 - 8 * i -: 8]) begin
        errors++;
        $display("FAIL abort%0d_byte%0d: got %h want %h", k, i, txq[b0 + i], e[47 - 8 * i -: 8]);
      end
    end
  endtask
  task automatic test_reset_mid_report;
    int b0 = txq.size();
    int d0 = done_cnt;
    int s1, k;
    bit ok;
    logic [15:0] c;
    logic [47:0] e;
    ref_go(1, c);
    e = {5'd0, r_pc, r_acc, c};
    @(negedge clk);
    strobe(CMD_STEP);
    k = 0;
    while (done_cnt < d0 + 2 && k < 200) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (done_cnt < d0 + 2) begin
      errors++;
      $display("FAIL midrst_wait: got %0d tx_done want 2", done_cnt - d0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    s1 = txq.size();
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got busy=%b tx_start=%b want 0 0", bus.busy, bus.tx_start);
    end
    checks++;
    if (s1 - b0 < 2 || txq[b0] !== e[47:40] || txq[b0 + 1] !== e[39:32]) begin
      errors++;
      $display("FAIL midrst_prefix: got %0d bytes want >=2 starting %h %h", s1 - b0, e[47:40], e[39:32]);
    end
    @(negedge clk);
    reset = 1'b1;
    r_pc = '0;
    r_acc = '0;
    repeat (30) @(negedge clk);
    checks++;
    if (txq.size() != s1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d extra bytes busy=%b want 0 0", txq.size() - s1, bus.busy);
    end
    send(CMD_STEP);
    wait_idle(ok);
    ref_go(1, c);
    e = {5'd0, r_pc, r_acc, c};
    checks++;
    if (!ok || txq.size() - s1 != 6) begin
      errors++;
      $display("FAIL midrst_fresh_bytes: got %0d idle=%b want 6", txq.size() - s1, ok);
    end else for (int i = 0; i < 6; i++) begin
      checks++;
      if (txq[s1 + i] !== e[47 - 8 * i -: 8]) begin
        errors++;
        $display("FAIL midrst_byte%0d: got %h want %h", i, txq[s1 + i], e[47 - 8 * i -: 8]);
      end
    end
  endtask
  task automatic test_protocol;
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL tx_handshake: got %0d early tx_start want 0", proto_err);
    end
  endtask
  initial begin
    logic [15:0] loop_prog [$];
    loop_prog.push_back(16'h0800);
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    test_reset;
    test_load;
    test_run;
    test_step;
    load_prog(loop_prog);
    test_abort(100);
    test_abort($urandom_range(5, 300));
    test_abort(70000);
    test_reset_mid_report;
    test_protocol;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
